wbu: RTL and testbench

The write-back unit is the final stage of the multi-cycle core and sits directly downstream of the LSU. It accepts one retired instruction per handshake from the LSU and commits its results: `wd` to the GPR file and `csr_wd` to the CSR file. It handles `ecall` trap entry and `ebreak` halt, and returns the next PC to the IFU with a one-cycle valid pulse. It also owns the architectural register file and serves the combinational read ports used by the IDU.

---
 rtl/wbu.sv | 126 ++++++++++++
 tb/tb_wbu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// wbu: write-back stage committing GPR/CSR results, ecall/ebreak handling and next-PC return
module wbu #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_receive_valid,
  input  logic [31:0] wd,
  input  logic [31:0] csr_wd,
  input  logic [4:0]  rd,
  input  logic [1:0]  csr_rd,
  input  logic        reg_write_en,
  input  logic        csreg_write_en,
  input  logic        ecall,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [31:0] instruction,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic [1:0]  csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        wbu_send_ready,
  output logic        wbu_send_valid,
  output logic [31:0] pc_update,
  output logic        halt,
  output logic [63:0] retire_count,
  output logic        wbu_state
);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd1, HALT = 2'd2} state_t;
  state_t      state_q;
  logic [31:0] wd_q, csr_wd_q, pc_q, pc_next_q, instr_q, pc_update_q, pc_d;
  logic [4:0]  rd_q;
  logic [1:0]  csr_rd_q;
  logic        we_q, cwe_q, ecall_q, ready_q, valid_q, halt_q;
  logic [63:0] retire_q;
  logic [31:0] gpr_q [32];
  logic [31:0] csr_q [4];

  // trap entry jumps to the mtvec value held before the commit edge
  assign pc_d           = ecall_q ? csr_q[1] : pc_next_q;
  assign rdata1         = raddr1 == 5'd0 ? 32'd0 : gpr_q[raddr1];
  assign rdata2         = raddr2 == 5'd0 ? 32'd0 : gpr_q[raddr2];
  assign csr_rdata      = csr_q[csr_raddr];
  assign wbu_send_ready = ready_q;
  assign wbu_send_valid = valid_q;
  assign pc_update      = pc_update_q;
  assign halt           = halt_q;
  assign retire_count   = retire_q;
  assign wbu_state      = (state_q == IDLE && wbu_receive_valid) || state_q == COMMIT;

  // control FSM: accept in IDLE, commit for one cycle, HALT absorbs after ebreak
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      csr_wd_q    <= '0;
      pc_q        <= '0;
      pc_next_q   <= '0;
      instr_q     <= '0;
      rd_q        <= '0;
      csr_rd_q    <= '0;
      we_q        <= 1'b0;
      cwe_q       <= 1'b0;
      ecall_q     <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      halt_q      <= 1'b0;
      pc_update_q <= RESET_PC;
      retire_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          ready_q <= wbu_receive_valid;
          if (wbu_receive_valid) begin
            state_q   <= COMMIT;
            wd_q      <= wd;
            csr_wd_q  <= csr_wd;
            pc_q      <= pc;
            pc_next_q <= pc_next;
            instr_q   <= instruction;
            rd_q      <= rd;
            csr_rd_q  <= csr_rd;
            we_q      <= reg_write_en;
            cwe_q     <= csreg_write_en;
            ecall_q   <= ecall;
          end
        end
        COMMIT: begin
          valid_q     <= 1'b1;
          ready_q     <= 1'b0;
          pc_update_q <= pc_d;
          retire_q    <= retire_q + 64'd1;
          state_q     <= instr_q == EBREAK ? HALT : IDLE;
          halt_q      <= halt_q | (instr_q == EBREAK);
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // architectural GPR/CSR state, written only at the commit edge; ecall wins over mepc/mcause writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
      csr_q[0] <= MSTATUS_RESET;
      csr_q[1] <= '0;
      csr_q[2] <= '0;
      csr_q[3] <= '0;
    end else if (state_q == COMMIT) begin
      if (we_q && rd_q != 5'd0) gpr_q[rd_q] <= wd_q;
      if (cwe_q) csr_q[csr_rd_q] <= csr_wd_q;
      if (ecall_q) begin
        csr_q[2] <= pc_q;
        csr_q[3] <= 32'd11;
      end
    end
  end
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: table vectors, random transactions against a reference model, and corner sequences
module tb_wbu;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  logic        clk = 0, rst = 0, wbu_receive_valid = 0;
  logic [31:0] wd = 0, csr_wd = 0, pc = 0, pc_next = 0, instruction = 0;
  logic [4:0]  rd = 0, raddr1 = 0, raddr2 = 0;
  logic [1:0]  csr_rd = 0, csr_raddr = 0;
  logic        reg_write_en = 0, csreg_write_en = 0, ecall = 0;
  logic [31:0] rdata1, rdata2, csr_rdata, pc_update;
  logic        wbu_send_ready, wbu_send_valid, halt, wbu_state;
  logic [63:0] retire_count;
  int          n_chk = 0, n_fail = 0;

  logic [31:0] gpr_m [32];
  logic [31:0] csr_m [4];
  logic [31:0] pc_m;
  logic [63:0] cnt_m;
  logic        halt_m;

  typedef struct {
    logic [4:0] rd; logic [31:0] wd; logic we;
    logic [1:0] crd; logic [31:0] cwd; logic cwe; logic ec;
    logic [31:0] pc; logic [31:0] pcn; logic [31:0] ins;
    logic [31:0] e_pc; logic [31:0] e_r; logic [31:0] e_csr; logic chk_e;
  } vec_t;
  vec_t vecs [4];

  wbu dut (
    .clk(clk), .rst(rst), .wbu_receive_valid(wbu_receive_valid), .wd(wd), .csr_wd(csr_wd),
    .rd(rd), .csr_rd(csr_rd), .reg_write_en(reg_write_en), .csreg_write_en(csreg_write_en),
    .ecall(ecall), .pc(pc), .pc_next(pc_next), .instruction(instruction),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .wbu_send_ready(wbu_send_ready),
    .wbu_send_valid(wbu_send_valid), .pc_update(pc_update), .halt(halt),
    .retire_count(retire_count), .wbu_state(wbu_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gpr_m[i] = 0;
    csr_m[0] = 32'h0000_1800; csr_m[1] = 0; csr_m[2] = 0; csr_m[3] = 0;
    pc_m = 32'h8000_0000; cnt_m = 0; halt_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    wbu_receive_valid = 0;
    model_reset();
    #1;
    chk("rst_ready", wbu_send_ready, 0);
    chk("rst_valid", wbu_send_valid, 0);
    chk("rst_pc", pc_update, 32'h8000_0000);
    chk("rst_cnt", retire_count, 0);
    chk("rst_halt", halt, 0);
    csr_raddr = 0; #1 chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [31:0] old_mtvec;
    @(negedge clk);
    rd = v.rd; wd = v.wd; reg_write_en = v.we; csr_rd = v.crd; csr_wd = v.cwd;
    csreg_write_en = v.cwe; ecall = v.ec; pc = v.pc; pc_next = v.pcn; instruction = v.ins;
    wbu_receive_valid = 1;
    #1 chk({tag, "_busy_idle"}, wbu_state, 1);
    @(posedge clk); @(negedge clk);
    chk({tag, "_ready"}, wbu_send_ready, 1);
    chk({tag, "_valid_early"}, wbu_send_valid, 0);
    chk({tag, "_busy_commit"}, wbu_state, 1);
    raddr1 = v.rd;
    #1 chk({tag, "_nobypass"}, rdata1, gpr_m[v.rd]);
    wbu_receive_valid = 0;
    wd = $urandom; pc_next = $urandom;
    if (v.we && v.rd != 0) gpr_m[v.rd] = v.wd;
    old_mtvec = csr_m[1];
    if (v.cwe) csr_m[v.crd] = v.cwd;
    if (v.ec) begin
      csr_m[2] = v.pc;
      csr_m[3] = 11;
    end
    pc_m = v.ec ? old_mtvec : v.pcn;
    cnt_m = cnt_m + 1;
    if (v.ins == EBREAK) halt_m = 1;
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid"}, wbu_send_valid, 1);
    chk({tag, "_ready_low"}, wbu_send_ready, 0);
    chk({tag, "_pc"}, pc_update, pc_m);
    chk({tag, "_cnt"}, retire_count, cnt_m);
    chk({tag, "_halt"}, halt, halt_m);
    raddr1 = v.rd; raddr2 = 5'($urandom);
    #1;
    chk({tag, "_rdata1"}, rdata1, gpr_m[v.rd]);
    chk({tag, "_rdata2"}, rdata2, gpr_m[raddr2]);
    for (int i = 0; i < 4; i++) begin
      csr_raddr = 2'(i);
      #1 chk({tag, "_csr"}, csr_rdata, csr_m[i]);
    end
    if (v.chk_e) begin
      chk({tag, "_tbl_pc"}, pc_update, v.e_pc);
      chk({tag, "_tbl_r"}, rdata1, v.e_r);
      csr_raddr = v.crd;
      #1 chk({tag, "_tbl_csr"}, csr_rdata, v.e_csr);
    end
  endtask

  initial begin
    vec_t v;
    int nr, nv;
    vecs[0] = '{5'd5, 32'hDEAD_BEEF, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0004, NOP,
                32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_1800, 1'b1};
    vecs[1] = '{5'd0, 32'h0000_1234, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_0004, 32'h8000_0008, NOP,
                32'h8000_0008, 32'h0, 32'h0000_1800, 1'b1};
    vecs[2] = '{5'd5, 32'h5555_5555, 1'b0, 2'd1, 32'h8000_0100, 1'b1, 1'b0, 32'h8000_0008, 32'h8000_000C, NOP,
                32'h8000_000C, 32'hDEAD_BEEF, 32'h8000_0100, 1'b1};
    vecs[3] = '{5'd0, 32'h0, 1'b0, 2'd2, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0040, 32'h8000_0044, 32'h0000_0073,
                32'h8000_0100, 32'h0, 32'h8000_0040, 1'b1};
    model_reset();
    do_reset();
    for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("tbl%0d", i));
    csr_raddr = 3; #1 chk("ecall_mcause", csr_rdata, 11);

    for (int i = 0; i < 60; i++) begin
      v.rd = 5'($urandom); v.wd = $urandom; v.we = 1'($urandom);
      v.crd = 2'($urandom); v.cwd = $urandom; v.cwe = ($urandom % 3) == 0; v.ec = ($urandom % 5) == 0;
      v.pc = $urandom; v.pcn = $urandom; v.ins = $urandom;
      if (v.ins == EBREAK) v.ins = NOP;
      v.e_pc = 0; v.e_r = 0; v.e_csr = 0; v.chk_e = 0;
      run_txn(v, $sformatf("rnd%0d", i));
    end

    do_reset();
    @(negedge clk);
    reg_write_en = 0; csreg_write_en = 0; ecall = 0; instruction = NOP; pc_next = 32'h8000_0200;
    wbu_receive_valid = 1;
    nr = 0; nv = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); @(negedge clk);
      nr += int'(wbu_send_ready);
      nv += int'(wbu_send_valid);
    end
    wbu_receive_valid = 0;
    chk("stream_ready", 64'(nr), 100);
    chk("stream_valid", 64'(nv), 100);
    chk("stream_cnt", retire_count, 100);

    do_reset();
    @(negedge clk);
    rd = 7; wd = 32'hCAFE_F00D; reg_write_en = 1; csreg_write_en = 1; csr_rd = 2; csr_wd = 32'h1111_2222;
    ecall = 0; instruction = NOP; pc_next = 32'h8000_0300;
    wbu_receive_valid = 1;
    @(posedge clk); @(negedge clk);
    chk("arst_ready_pre", wbu_send_ready, 1);
    wbu_receive_valid = 0;
    rst = 0;
    #1;
    chk("arst_ready", wbu_send_ready, 0);
    chk("arst_valid", wbu_send_valid, 0);
    chk("arst_pc", pc_update, 32'h8000_0000);
    chk("arst_cnt", retire_count, 0);
    @(posedge clk); @(negedge clk);
    rst = 1;
    raddr1 = 7; csr_raddr = 2;
    #1;
    chk("arst_gpr", rdata1, 0);
    chk("arst_mepc", csr_rdata, 0);
    model_reset();

    v = '{5'd3, 32'h0000_00AA, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_0010, 32'h8000_0014, EBREAK,
          32'h0, 32'h0, 32'h0, 1'b0};
    run_txn(v, "ebreak");
    @(negedge clk);
    chk("ebreak_valid_drop", wbu_send_valid, 0);
    chk("ebreak_halt", halt, 1);
    wbu_receive_valid = 1;
    nr = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      nr += int'(wbu_send_ready) + int'(wbu_send_valid) + int'(wbu_state);
    end
    wbu_receive_valid = 0;
    chk("halt_ignore", 64'(nr), 0);
    chk("halt_cnt", retire_count, 1);
    chk("halt_pc", pc_update, 32'h8000_0014);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
